// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h00000013;
  localparam logic [XLEN-1:0] HALT_INSTR = 32'h000f0033;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, redirect request and decode handshake.
interface fetch_queue_if #(
  parameter int IMEM_AW = 12
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               id_ready;
  logic               id_valid;
  logic [31:0]        id_pc;
  logic [31:0]        id_instr;

  // master is the fetch queue itself; slave is memory plus decode/execute
  modport master (
    output imem_addr, id_valid, id_pc, id_instr,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_addr, id_valid, id_pc, id_instr,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// fq_fifo: DEPTH-entry circular buffer of {pc, instr} with flush and a registered head.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fq_entry_t     wr_data,
  output fq_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  fq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // power-of-two depth: pointers wrap by natural overflow
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (ce) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ce && push_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC generation, halt detection and redirect flush around fq_fifo.
// Define FETCH_QUEUE_BYPASS_EN to forward the fetched word straight to decode when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          IMEM_AW  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  fetch_queue_if.master            bus,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        halted_q, halted_d;
  fq_entry_t   head, wr_entry;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic        fetch_ok, hit_halt;

  assign fetch_ok = !halted_q && !fifo_full && !bus.redirect_valid;
  assign hit_halt = fetch_ok && (bus.imem_rdata == HALT_INSTR);
  assign fifo_pop = !fifo_empty && bus.id_ready && !bus.redirect_valid;
  assign wr_entry = '{pc: fetch_pc_q, instr: bus.imem_rdata};

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass    = fifo_empty && !halted_q && !bus.redirect_valid;
  // a bypassed word taken by decode is never written into the queue
  assign fifo_push = fetch_ok && !(bypass && bus.id_ready);
`else
  assign fifo_push = fetch_ok;
`endif

  assign bus.imem_addr = fetch_pc_q[IMEM_AW+1:2];
  assign halted        = halted_q;

  always_comb begin
    bus.id_valid = !fifo_empty;
    bus.id_pc    = fifo_empty ? '0 : head.pc;
    bus.id_instr = fifo_empty ? NOP_INSTR : head.instr;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass) begin
      bus.id_valid = 1'b1;
      bus.id_pc    = fetch_pc_q;
      bus.id_instr = bus.imem_rdata;
    end
`endif
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & 32'hffff_fffc;
      halted_d   = 1'b0;
    end else if (fetch_ok) begin
      // the sentinel is queued but fetch parks on its address
      if (hit_halt) halted_d = 1'b1;
      else          fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      halted_q   <= 1'b0;
    end else if (ce) begin
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
    end
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (bus.redirect_valid),
    .wr_data (wr_entry),
    .head    (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected {pc, instr} deliveries are queued and checked at each handshake.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b1;
  logic       halted;
  logic [2:0] count;

  always #5 clk = ~clk;

  fetch_queue_if #(.IMEM_AW(12)) bus ();

  logic [31:0] imem [4096];
  assign bus.imem_rdata = imem[bus.imem_addr];

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .IMEM_AW(12)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .bus    (bus),
    .halted (halted),
    .count  (count)
  );

  int        n_cmp = 0;
  int        n_bad = 0;
  fq_entry_t sb [$];
  fq_entry_t mon_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addi(input int i);
    return (32'(i) << 20) | 32'h00000093;
  endfunction

  task automatic expect_pc(input int pc);
    sb.push_back('{pc: 32'(pc), instr: addi(pc / 4)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    ce  = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = rdy;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) step();
    check_eq({tag, "_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
    bus.id_ready = 1'b0;
  endtask

  // handshake completes at the next posedge; inputs only change just after posedges
  always @(negedge clk) begin
    if (!rst && ce && !bus.redirect_valid && bus.id_valid && bus.id_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_pop", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        $display("txn pc=%h instr=%h", bus.id_pc, bus.id_instr);
        check_eq("pop_pc", bus.id_pc, mon_e.pc);
        check_eq("pop_instr", bus.id_instr, mon_e.instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) imem[i] = addi(i);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;

    // reset state then streaming at one instruction per cycle
    do_reset(1'b1);
    check_eq("rst_valid", 32'(bus.id_valid), 32'd0);
    check_eq("rst_pc", bus.id_pc, 32'h0);
    check_eq("rst_instr", bus.id_instr, NOP_INSTR);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_addr", 32'(bus.imem_addr), 32'd0);
    for (int i = 0; i < 8; i++) expect_pc(i * 4);
    step();
    check_eq("first_valid", 32'(bus.id_valid), 32'd1);
    check_eq("first_pc", bus.id_pc, 32'h0);
    drain("stream");

    // backpressure fills the queue and parks fetch at 0x10
    do_reset(1'b0);
    repeat (6) step();
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_addr", 32'(bus.imem_addr), 32'd4);
    check_eq("full_head", bus.id_pc, 32'h0);
    for (int i = 0; i < 5; i++) expect_pc(i * 4);
    bus.id_ready = 1'b1;
    drain("release");

    // pop while full: no push that cycle, refill next
    do_reset(1'b0);
    repeat (5) step();
    check_eq("pf_count4", 32'(count), 32'd4);
    expect_pc(0);
    bus.id_ready = 1'b1;
    step();
    bus.id_ready = 1'b0;
    check_eq("pf_count3", 32'(count), 32'd3);
    step();
    check_eq("pf_refill", 32'(count), 32'd4);
    sb.delete();

    // simultaneous push and pop at count 2
    do_reset(1'b0);
    step();
    step();
    check_eq("pp_count_pre", 32'(count), 32'd2);
    expect_pc(0);
    bus.id_ready = 1'b1;
    step();
    bus.id_ready = 1'b0;
    check_eq("pp_count", 32'(count), 32'd2);
    check_eq("pp_head", bus.id_pc, 32'h4);
    sb.delete();

    // redirect flushes and restarts with one bubble
    do_reset(1'b0);
    repeat (3) step();
    check_eq("rd_count_pre", 32'(count), 32'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h43;
    bus.id_ready       = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("rd_count", 32'(count), 32'd0);
    check_eq("rd_valid", 32'(bus.id_valid), 32'd0);
    check_eq("rd_addr", 32'(bus.imem_addr), 32'h10);
    expect_pc(32'h40);
    expect_pc(32'h44);
    expect_pc(32'h48);
    step();
    check_eq("rd_valid2", 32'(bus.id_valid), 32'd1);
    check_eq("rd_pc2", bus.id_pc, 32'h40);
    drain("redirect");

    // halt sentinel at 0xC is delivered, then fetch stops
    imem[3] = HALT_INSTR;
    do_reset(1'b1);
    expect_pc(0);
    expect_pc(4);
    expect_pc(8);
    sb.push_back('{pc: 32'hC, instr: HALT_INSTR});
    drain("halt");
    step();
    step();
    check_eq("halt_flag", 32'(halted), 32'd1);
    check_eq("halt_addr", 32'(bus.imem_addr), 32'd3);
    check_eq("halt_valid", 32'(bus.id_valid), 32'd0);
    check_eq("halt_count", 32'(count), 32'd0);
    check_eq("halt_instr", bus.id_instr, NOP_INSTR);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("unhalt_flag", 32'(halted), 32'd0);
    repeat (5) step();
    check_eq("rehalt_count", 32'(count), 32'd4);
    check_eq("rehalt_flag", 32'(halted), 32'd1);
    check_eq("rehalt_addr", 32'(bus.imem_addr), 32'd3);
    imem[3] = addi(3);

    // reset mid-stream
    do_reset(1'b0);
    repeat (3) step();
    check_eq("mr_count_pre", 32'(count), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mr_valid", 32'(bus.id_valid), 32'd0);
    check_eq("mr_count", 32'(count), 32'd0);
    check_eq("mr_addr", 32'(bus.imem_addr), 32'd0);

    // ce low freezes everything, including redirect and id_ready
    do_reset(1'b0);
    step();
    step();
    ce = 1'b0;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("ce_count", 32'(count), 32'd2);
      check_eq("ce_valid", 32'(bus.id_valid), 32'd1);
      check_eq("ce_pc", bus.id_pc, 32'h0);
      check_eq("ce_addr", 32'(bus.imem_addr), 32'd2);
    end
    ce = 1'b1;
    bus.redirect_valid = 1'b0;
    expect_pc(0);
    expect_pc(4);
    drain("ce");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
